// File: rtl/fifo_prog.sv
// Synchronous FIFO with run-time programmable almost-full/almost-empty thresholds,
// registered read data and a sticky overflow/underflow error flag.
`timescale 1ns/1ps

module fifo_prog #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 4,
    parameter int AF_RST = 12,
    parameter int AE_RST = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] af_thr_i,
    input  logic [ADDR_W-1:0] ae_thr_i,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              error
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] af_thr;
    logic [ADDR_W-1:0] ae_thr;
    logic              push_ok;
    logic              pop_ok;
    logic              overflow;
    logic              underflow;

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH_CNT);
        almost_full  = (count >= {1'b0, af_thr});
        almost_empty = (count <= {1'b0, ae_thr});
        pop_ok       = pop & ~empty;
        push_ok      = push & (~full | pop);
        overflow     = push & full & ~pop;
        underflow    = pop & empty;
    end

    // Storage is deliberately left out of reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
            af_thr   <= ADDR_W'(AF_RST);
            ae_thr   <= ADDR_W'(AE_RST);
        end else begin
            valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (overflow || underflow) begin
                error <= 1'b1;
            end
            if (cfg_load) begin
                af_thr <= af_thr_i;
                ae_thr <= ae_thr_i;
            end
        end
    end

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog: one task per scenario, expected values
// computed by hand from the FIFO's ordering, occupancy and threshold behaviour.
`timescale 1ns/1ps

module tb_fifo_prog;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] af_thr_i = '0;
    logic [3:0] ae_thr_i = '0;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [5:0] data_out;
    logic       valid;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       error;

    int passed = 0;
    int total  = 0;

    fifo_prog dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_load     (cfg_load),
        .af_thr_i     (af_thr_i),
        .ae_thr_i     (ae_thr_i),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid        (valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after each rising edge; outputs are sampled at the same point.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        push     = 1'b0;
        pop      = 1'b0;
        cfg_load = 1'b0;
        data_in  = '0;
        af_thr_i = '0;
        ae_thr_i = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 1; i <= n; i++) begin
            push    = 1'b1;
            data_in = 6'(base + i);
            tick();
        end
        push = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++; if (count !== 5'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else passed++;
        total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) $display("[TB] FAIL reset_flags got %b want 1010", {empty, full, almost_empty, almost_full}); else passed++;
        total++; if ({valid, error} !== 2'b00) $display("[TB] FAIL reset_valid_error got %b want 00", {valid, error}); else passed++;
        total++; if (data_out !== 6'd0) $display("[TB] FAIL reset_data_out got %0d want 0", data_out); else passed++;
    endtask

    task automatic test_fill_drain;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            push    = 1'b1;
            data_in = 6'(i);
            tick();
            total++; if (count !== 5'(i)) $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count, i); else passed++;
            total++; if (almost_full !== (i >= 12)) $display("[TB] FAIL fill_af[%0d] got %b want %b", i, almost_full, (i >= 12)); else passed++;
            total++; if (full !== (i == 16)) $display("[TB] FAIL fill_full[%0d] got %b want %b", i, full, (i == 16)); else passed++;
        end
        push = 1'b0;
        total++; if (error !== 1'b0) $display("[TB] FAIL fill_error got %b want 0", error); else passed++;
        for (int i = 1; i <= 16; i++) begin
            pop = 1'b1;
            tick();
            total++; if (data_out !== 6'(i)) $display("[TB] FAIL drain_data[%0d] got %0d want %0d", i, data_out, i); else passed++;
            total++; if (valid !== 1'b1) $display("[TB] FAIL drain_valid[%0d] got %b want 1", i, valid); else passed++;
            total++; if (almost_empty !== ((16 - i) <= 3)) $display("[TB] FAIL drain_ae[%0d] got %b want %b", i, almost_empty, ((16 - i) <= 3)); else passed++;
        end
        pop = 1'b0;
        tick();
        total++; if ({empty, valid} !== 2'b10) $display("[TB] FAIL drain_end_empty_valid got %b want 10", {empty, valid}); else passed++;
        total++; if (data_out !== 6'd16) $display("[TB] FAIL drain_hold got %0d want 16", data_out); else passed++;
        total++; if (error !== 1'b0) $display("[TB] FAIL drain_error got %b want 0", error); else passed++;
    endtask

    task automatic test_overflow;
        do_reset();
        fill(16, 0);
        push    = 1'b1;
        data_in = 6'd63;
        tick();
        push = 1'b0;
        total++; if (count !== 5'd16) $display("[TB] FAIL ovf_count got %0d want 16", count); else passed++;
        total++; if (error !== 1'b1) $display("[TB] FAIL ovf_error got %b want 1", error); else passed++;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++; if (data_out !== 6'd1) $display("[TB] FAIL ovf_first_pop got %0d want 1", data_out); else passed++;
        fill(1, 20);
        tick();
        total++; if (error !== 1'b1) $display("[TB] FAIL ovf_sticky got %b want 1", error); else passed++;
        do_reset();
        #1;
        total++; if (error !== 1'b0) $display("[TB] FAIL ovf_cleared got %b want 0", error); else passed++;
    endtask

    task automatic test_empty_push_pop;
        do_reset();
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 6'd5;
        tick();
        push = 1'b0;
        total++; if (count !== 5'd1) $display("[TB] FAIL epp_count got %0d want 1", count); else passed++;
        total++; if ({valid, error} !== 2'b01) $display("[TB] FAIL epp_valid_error got %b want 01", {valid, error}); else passed++;
        total++; if (data_out !== 6'd0) $display("[TB] FAIL epp_data_hold got %0d want 0", data_out); else passed++;
        tick();
        pop = 1'b0;
        total++; if (data_out !== 6'd5) $display("[TB] FAIL epp_next_pop got %0d want 5", data_out); else passed++;
        total++; if ({valid, empty} !== 2'b11) $display("[TB] FAIL epp_valid_empty got %b want 11", {valid, empty}); else passed++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        fill(16, 0);
        for (int k = 0; k < 20; k++) begin
            push    = 1'b1;
            pop     = 1'b1;
            data_in = 6'(17 + k);
            tick();
            total++; if (data_out !== 6'(k + 1)) $display("[TB] FAIL b2b_data[%0d] got %0d want %0d", k, data_out, k + 1); else passed++;
            total++; if (count !== 5'd16) $display("[TB] FAIL b2b_count[%0d] got %0d want 16", k, count); else passed++;
        end
        push = 1'b0;
        total++; if (error !== 1'b0) $display("[TB] FAIL b2b_error got %b want 0", error); else passed++;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++; if (data_out !== 6'(21 + k)) $display("[TB] FAIL b2b_drain[%0d] got %0d want %0d", k, data_out, 21 + k); else passed++;
        end
        pop = 1'b0;
        total++; if (empty !== 1'b1) $display("[TB] FAIL b2b_empty got %b want 1", empty); else passed++;
    endtask

    task automatic test_thresholds;
        do_reset();
        fill(4, 0);
        total++; if ({almost_full, almost_empty} !== 2'b00) $display("[TB] FAIL thr_default got %b want 00", {almost_full, almost_empty}); else passed++;
        cfg_load = 1'b1;
        af_thr_i = 4'd4;
        ae_thr_i = 4'd1;
        tick();
        cfg_load = 1'b0;
        total++; if ({almost_full, almost_empty} !== 2'b10) $display("[TB] FAIL thr_loaded got %b want 10", {almost_full, almost_empty}); else passed++;
        total++; if ({count, error} !== {5'd4, 1'b0}) $display("[TB] FAIL thr_no_side_effect got %b want 001000", {count, error}); else passed++;
        pop = 1'b1;
        tick();
        total++; if ({almost_full, almost_empty} !== 2'b00) $display("[TB] FAIL thr_pop1 got %b want 00", {almost_full, almost_empty}); else passed++;
        tick();
        total++; if (almost_empty !== 1'b0) $display("[TB] FAIL thr_pop2 got %b want 0", almost_empty); else passed++;
        tick();
        pop = 1'b0;
        total++; if ({count, almost_empty} !== {5'd1, 1'b1}) $display("[TB] FAIL thr_pop3 got %b want 000011", {count, almost_empty}); else passed++;
    endtask

    task automatic test_async_reset;
        do_reset();
        fill(10, 40);
        pop = 1'b1;
        tick();
        pop      = 1'b0;
        cfg_load = 1'b1;
        af_thr_i = 4'd2;
        ae_thr_i = 4'd8;
        tick();
        cfg_load = 1'b0;
        total++; if ({count, data_out} !== {5'd9, 6'd41}) $display("[TB] FAIL ar_pre got %0d/%0d want 9/41", count, data_out); else passed++;
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 6'd7;
        #2;
        reset = 1'b1;
        #1;
        total++; if (count !== 5'd0) $display("[TB] FAIL ar_count got %0d want 0", count); else passed++;
        total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) $display("[TB] FAIL ar_flags got %b want 1010", {empty, full, almost_empty, almost_full}); else passed++;
        total++; if ({data_out, valid, error} !== 8'd0) $display("[TB] FAIL ar_outputs got %b want 0", {data_out, valid, error}); else passed++;
        tick();
        total++; if ({count, valid} !== 6'd0) $display("[TB] FAIL ar_ignore_traffic got %b want 0", {count, valid}); else passed++;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        fill(4, 0);
        total++; if ({almost_full, almost_empty} !== 2'b00) $display("[TB] FAIL ar_thr_revert got %b want 00", {almost_full, almost_empty}); else passed++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_empty_push_pop();
        test_back_to_back();
        test_thresholds();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 Parameter DATA_W, default 6, width of each FIFO word.
REQ-002 Parameter ADDR_W, default 4; depth DEPTH = 2**ADDR_W (16).
REQ-003 Parameter AF_RST, default 12, almost-full threshold in effect after reset.
REQ-004 Parameter AE_RST, default 3, almost-empty threshold in effect after reset.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cfg_load  in  1  when high, capture af_thr_i/ae_thr_i into threshold registers.
REQ-008 af_thr_i  in  ADDR_W  almost-full threshold from the controller.
REQ-009 ae_thr_i  in  ADDR_W  almost-empty threshold from the controller.
REQ-010 push  in  1  write request.
REQ-011 data_in  in  DATA_W  write data.
REQ-012 pop  in  1  read request.
REQ-013 data_out  out  DATA_W  registered read data.
REQ-014 valid  out  1  data_out holds a newly popped word this cycle.
REQ-015 count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-016 empty / full  out  1 each  count==0 / count==DEPTH.
REQ-017 almost_empty / almost_full  out  1 each  threshold status.
REQ-018 error  out  1  sticky overflow/underflow flag, the per-FIFO bit of the controller's error vector.

Function
REQ-019 Storage is a DEPTH-entry register array with ADDR_W-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-020 Accepted push (push & ~full) writes data_in at wr_ptr, then increments wr_ptr.
REQ-021 Accepted pop (pop & ~empty) loads mem[rd_ptr] into data_out on the same clock edge and increments rd_ptr; valid=1 in the following cycle only, else valid=0.
REQ-022 Pop latency: data visible on data_out exactly 1 cycle after the pop edge; data_out holds its last value when no pop is accepted.
REQ-023 count: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted.
REQ-024 Simultaneous push & pop when full: both accepted, count stays DEPTH, no error.
REQ-025 Simultaneous push & pop when empty: push accepted, pop rejected as underflow, count becomes 1, error set.
REQ-026 Push when full without pop: word dropped, pointers/count unchanged, error set.
REQ-027 Pop when empty: pointers/count/data_out unchanged, valid=0, error set.
REQ-028 error is sticky: once set, it stays 1 until reset; no other clear path.
REQ-029 almost_full = (count >= af_thr); almost_empty = (count <= ae_thr); unsigned compare, thresholds zero-extended to ADDR_W+1 bits.
REQ-030 Threshold registers update on the clock edge where cfg_load=1, at any time; flags reflect new thresholds from the next cycle.
REQ-031 cfg_load does not affect data, pointers, count or error.
REQ-032 empty, full, almost_* are combinational from count and thresholds, glitch-free relative to clk (no input-to-output paths).

Reset
REQ-033 reset=1 immediately forces wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid=0, error=0, af_thr=AF_RST, ae_thr=AE_RST; memory contents are not cleared.
REQ-034 After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-035 Reset asserted mid-transfer discards all stored words; push/pop sampled while reset=1 are ignored.

Verification
REQ-036 Reset, then 16 pushes of 1..16 -> count=16, full=1, almost_full from 12th push, error=0; 16 pops -> data_out 1..16 in order, each 1 cycle after pop, valid pulses, empty=1.
REQ-037 Full FIFO, push=1 with pop=0 -> count stays 16, error=1 and stays 1 through later legal traffic until reset.
REQ-038 Empty FIFO, push=1 & pop=1 with data_in=5 -> count=1, valid=0, error=1; next pop returns 5.
REQ-039 Full FIFO, push & pop together for 20 cycles -> count=16 constant, FIFO order preserved across pointer wrap, error=0.
REQ-040 cfg_load with af_thr_i=4, ae_thr_i=1 at count=4 -> next cycle almost_full=1, almost_empty=0; pop 3 -> almost_empty=1.
REQ-041 Assert reset asynchronously between clock edges with count=9 -> outputs reach reset values before the next edge; thresholds revert to 12/3.
